writeback_lsu: RTL and testbench

WRITEBACK_LSU -- requirements
Module: writeback_lsu

---
 rtl/writeback_lsu.sv | 197 +++++++++++++++++++
 tb/tb_writeback_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_lsu.sv
// Writeback/load-store stage: issues one memory request per load/store and muxes register writeback data.
// Optional WB_MISALIGN_TRAP_EN: flag misaligned accesses instead of issuing them.
module writeback_lsu #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              valid,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [2:0]        funct3,
  input  logic              reg_we,
  input  logic              mem_we,
  input  logic              mem_rr,
  input  logic              jump,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic              mem_wr,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   writeback,
  output logic              wb_valid,
  output logic              hold,
  output logic              misalign
);

  localparam int MASK_W = XLEN / 8;
  localparam int LANE_W = $clog2(MASK_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic              req_valid_r;
  logic [XLEN-1:0]   rdata_r;

  logic              mem_op_s;
  logic              misalign_s;
  logic              start_s;
  logic [LANE_W-1:0] lane_s;
  logic [XLEN-1:0]   shifted_s;
  logic [XLEN-1:0]   load_s;
  logic [XLEN-1:0]   writeback_s;
  logic [MASK_W-1:0] wmask_s;

  assign mem_op_s = mem_rr | mem_we;
  assign lane_s   = alu_result[LANE_W-1:0];
  assign start_s  = valid & mem_op_s & ~misalign_s;

  // Natural-alignment check; only meaningful for a fresh access sitting in IDLE.
  always_comb begin
    misalign_s = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
    if (!reset && valid && mem_op_s && (state_r == IDLE)) begin
      case (funct3[1:0])
        2'b00:   misalign_s = 1'b0;
        2'b01:   misalign_s = alu_result[0];
        2'b10:   misalign_s = |alu_result[1:0];
        2'b11:   misalign_s = |alu_result[2:0];
        default: misalign_s = 1'b0;
      endcase
    end else begin
      misalign_s = 1'b0;
    end
`else
    misalign_s = 1'b0;
`endif
  end

  // Request FSM; the request-valid flag is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      req_valid_r <= 1'b0;
      rdata_r     <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            req_valid_r <= 1'b0;
            if (mem_we) begin
              state_r <= DONE;
            end else if (mem_resp_valid) begin
              rdata_r <= mem_rdata;
              state_r <= DONE;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            rdata_r <= mem_rdata;
            state_r <= DONE;
          end
        end
        DONE: begin
          if (!stall) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Load extraction: shift the addressed lane down, then sign/zero-extend by size.
  always_comb begin
    shifted_s = rdata_r >> {lane_s, 3'b000};
    load_s    = {XLEN{1'b0}};
    case (funct3)
      3'b000:  load_s = XLEN'($signed(shifted_s[7:0]));
      3'b001:  load_s = XLEN'($signed(shifted_s[15:0]));
      3'b010:  load_s = XLEN'($signed(shifted_s[31:0]));
      3'b100:  load_s = XLEN'(shifted_s[7:0]);
      3'b101:  load_s = XLEN'(shifted_s[15:0]);
      3'b011: begin
        if (XLEN == 64) begin
          load_s = shifted_s;
        end else begin
          load_s = {XLEN{1'b0}};
        end
      end
      3'b110: begin
        if (XLEN == 64) begin
          load_s = XLEN'(shifted_s[31:0]);
        end else begin
          load_s = {XLEN{1'b0}};
        end
      end
      default: load_s = {XLEN{1'b0}};
    endcase
  end

  // Store byte enables: contiguous bytes starting at the addressed lane.
  always_comb begin
    wmask_s = {MASK_W{1'b0}};
    case (funct3)
      3'b000:  wmask_s = MASK_W'(1'b1) << lane_s;
      3'b001:  wmask_s = MASK_W'(2'b11) << lane_s;
      3'b010:  wmask_s = MASK_W'(4'hF) << lane_s;
      3'b011: begin
        if (XLEN == 64) begin
          wmask_s = MASK_W'(8'hFF) << lane_s;
        end else begin
          wmask_s = {MASK_W{1'b0}};
        end
      end
      default: wmask_s = {MASK_W{1'b0}};
    endcase
  end

  // Writeback source select; a trapped access writes zero.
  always_comb begin
    writeback_s = alu_result;
    if (misalign_s) begin
      writeback_s = {XLEN{1'b0}};
    end else if (reg_we && jump) begin
      writeback_s = pc + XLEN'(PC_INC);
    end else if (mem_rr) begin
      writeback_s = load_s;
    end else begin
      writeback_s = alu_result;
    end
  end

  assign mem_req_valid = req_valid_r & ~reset;
  assign mem_addr      = alu_result;
  assign mem_wdata     = store_data << {lane_s, 3'b000};
  assign mem_wmask     = wmask_s;
  assign mem_wr        = mem_we;
  assign writeback     = writeback_s;
  assign misalign      = misalign_s;
  assign hold          = valid & mem_op_s & (state_r != DONE) & ~misalign_s & ~reset;
  assign wb_valid      = misalign_s | (state_r == DONE) |
                         ((state_r == IDLE) & valid & ~mem_op_s);

endmodule

// File: tb/tb_writeback_lsu.sv
// Directed bench for writeback_lsu: XLEN=32 and XLEN=64 instances, hand-computed expectations.
module tb_writeback_lsu;

  logic clk = 1'b0;
  logic reset, stall;
  int   n_checks = 0;
  int   n_fail   = 0;

  // XLEN=32 instance signals
  logic        valid, reg_we, mem_we, mem_rr, jump, ready, resp;
  logic [31:0] pc, alu, sdata, rdata;
  logic [2:0]  f3;
  logic        mrv, mwr, wbv, hold, mis;
  logic [31:0] maddr, mwdata, wb;
  logic [3:0]  mwmask;

  // XLEN=64 instance signals
  logic        valid64, reg_we64, mem_we64, mem_rr64, jump64, ready64, resp64;
  logic [63:0] pc64, alu64, sdata64, rdata64;
  logic [2:0]  f364;
  logic        mrv64, mwr64, wbv64, hold64, mis64;
  logic [63:0] maddr64, mwdata64, wb64;
  logic [7:0]  mwmask64;

  always #5 clk = ~clk;

  writeback_lsu #(.XLEN(32), .PC_INC(4)) dut32 (
    .clk(clk), .reset(reset), .stall(stall), .valid(valid), .pc(pc),
    .alu_result(alu), .store_data(sdata), .funct3(f3), .reg_we(reg_we),
    .mem_we(mem_we), .mem_rr(mem_rr), .jump(jump), .mem_req_valid(mrv),
    .mem_req_ready(ready), .mem_addr(maddr), .mem_wdata(mwdata),
    .mem_wmask(mwmask), .mem_wr(mwr), .mem_resp_valid(resp), .mem_rdata(rdata),
    .writeback(wb), .wb_valid(wbv), .hold(hold), .misalign(mis)
  );

  writeback_lsu #(.XLEN(64), .PC_INC(4)) dut64 (
    .clk(clk), .reset(reset), .stall(stall), .valid(valid64), .pc(pc64),
    .alu_result(alu64), .store_data(sdata64), .funct3(f364), .reg_we(reg_we64),
    .mem_we(mem_we64), .mem_rr(mem_rr64), .jump(jump64), .mem_req_valid(mrv64),
    .mem_req_ready(ready64), .mem_addr(maddr64), .mem_wdata(mwdata64),
    .mem_wmask(mwmask64), .mem_wr(mwr64), .mem_resp_valid(resp64), .mem_rdata(rdata64),
    .writeback(wb64), .wb_valid(wbv64), .hold(hold64), .misalign(mis64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  sw_f3  [10];
  logic [31:0] sw_alu [10];
  logic [31:0] sw_exp [10];

  initial begin
    sw_f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b101, 3'b000, 3'b000, 3'b011, 3'b110};
    sw_alu = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2002, 32'h2002, 32'h2001, 32'h2003, 32'h2000, 32'h2000};
    sw_exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F80, 32'h0000_7F80, 32'hFFFF_8001,
               32'h0000_8001, 32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1; stall = 1'b0;
    valid = 1'b1; reg_we = 1'b0; mem_we = 1'b0; mem_rr = 1'b1; jump = 1'b0;
    ready = 1'b0; resp = 1'b0; pc = 32'h0; alu = 32'h0; sdata = 32'h0; rdata = 32'h0; f3 = 3'b010;
    valid64 = 1'b0; reg_we64 = 1'b0; mem_we64 = 1'b0; mem_rr64 = 1'b0; jump64 = 1'b0;
    ready64 = 1'b0; resp64 = 1'b0; pc64 = 64'h0; alu64 = 64'h0; sdata64 = 64'h0;
    rdata64 = 64'h0; f364 = 3'b000;

    // Reset cycle: a load is presented but nothing may be requested or held
    tick();
    check("rst_mrv", 64'(mrv), 64'h0);
    check("rst_hold", 64'(hold), 64'h0);
    check("rst_mis", 64'(mis), 64'h0);
    tick();
    reset = 1'b0; valid = 1'b0; mem_rr = 1'b0;
    #1;
    check("post_rst_mrv", 64'(mrv), 64'h0);
    check("post_rst_wbv", 64'(wbv), 64'h0);

    // Store lane placement and byte enables (XLEN=32)
    f3 = 3'b000; alu = 32'h1001; sdata = 32'h0000_00AB; #1;
    check("sb_wdata", 64'(mwdata), 64'h0000_AB00);
    check("sb_wmask", 64'(mwmask), 64'h2);
    f3 = 3'b001; alu = 32'h1002; sdata = 32'h0000_1234; #1;
    check("sh_wdata", 64'(mwdata), 64'h1234_0000);
    check("sh_wmask", 64'(mwmask), 64'hC);
    f3 = 3'b010; alu = 32'h1000; sdata = 32'hCAFE_F00D; #1;
    check("sw_wmask", 64'(mwmask), 64'hF);
    check("sw_addr", 64'(maddr), 64'h1000);
    f3 = 3'b011; #1;
    check("sd32_wmask", 64'(mwmask), 64'h0);

    // jalr link value and plain ALU writeback
    valid = 1'b1; reg_we = 1'b1; jump = 1'b1; pc = 32'h100; alu = 32'h2000; f3 = 3'b000; #1;
    check("jalr_wb", 64'(wb), 64'h104);
    check("jalr_wbv", 64'(wbv), 64'h1);
    check("jalr_hold", 64'(hold), 64'h0);
    jump = 1'b0; #1;
    check("alu_wb", 64'(wb), 64'h2000);

    // LB @0x1003, ready on 2nd REQ cycle, response 3 cycles later
    tick();
    mem_rr = 1'b1; f3 = 3'b000; alu = 32'h1003; #1;
    check("lb_idle_hold", 64'(hold), 64'h1);
    check("lb_idle_mrv", 64'(mrv), 64'h0);
    check("lb_idle_wbv", 64'(wbv), 64'h0);
    tick();
    check("lb_req_mrv", 64'(mrv), 64'h1);
    check("lb_req_wr", 64'(mwr), 64'h0);
    check("lb_req_addr", 64'(maddr), 64'h1003);
    tick();
    ready = 1'b1; #1;
    check("lb_req2_mrv", 64'(mrv), 64'h1);
    tick();
    ready = 1'b0; #1;
    check("lb_wait_mrv", 64'(mrv), 64'h0);
    check("lb_wait_hold", 64'(hold), 64'h1);
    tick();
    check("lb_wait2_hold", 64'(hold), 64'h1);
    tick();
    resp = 1'b1; rdata = 32'h80FF_FF00; #1;
    check("lb_wait3_hold", 64'(hold), 64'h1);
    tick();
    resp = 1'b0; rdata = 32'h1234_5678; #1;
    check("lb_done_wb", 64'(wb), 64'hFFFF_FF80);
    check("lb_done_wbv", 64'(wbv), 64'h1);
    check("lb_done_hold", 64'(hold), 64'h0);
    tick();
    valid = 1'b0; mem_rr = 1'b0; reg_we = 1'b0; #1;
    check("lb_idle_after", 64'(mrv), 64'h0);

    // LW with ready+resp together, then 2 stall cycles in DONE
    valid = 1'b1; mem_rr = 1'b1; reg_we = 1'b1; f3 = 3'b010; alu = 32'h2000;
    tick();
    ready = 1'b1; resp = 1'b1; rdata = 32'h8001_7F80; #1;
    check("lw_req_mrv", 64'(mrv), 64'h1);
    tick();
    ready = 1'b0; resp = 1'b0; rdata = 32'h0; stall = 1'b1; #1;
    check("lw_done_wb", 64'(wb), 64'h8001_7F80);
    check("lw_done_hold", 64'(hold), 64'h0);
    for (int s = 0; s < 2; s++) begin
      tick();
      check("stall_wb", 64'(wb), 64'h8001_7F80);
      check("stall_wbv", 64'(wbv), 64'h1);
      check("stall_hold", 64'(hold), 64'h0);
      check("stall_mrv", 64'(mrv), 64'h0);
    end
    for (int i = 0; i < 10; i++) begin
      f3 = sw_f3[i]; alu = sw_alu[i]; #1;
      check($sformatf("ldmask_%0d", i), 64'(wb), 64'(sw_exp[i]));
    end
    f3 = 3'b010; alu = 32'h2000; stall = 1'b0;
    tick();
    check("unstall_hold", 64'(hold), 64'h1);
    check("unstall_wbv", 64'(wbv), 64'h0);
    valid = 1'b0;

    // Reset while in WAIT, then a stale response
    tick();
    valid = 1'b1; alu = 32'h3000; ready = 1'b1;
    tick();
    tick();
    ready = 1'b0; reset = 1'b1; #1;
    check("rstwait_mrv", 64'(mrv), 64'h0);
    check("rstwait_hold", 64'(hold), 64'h0);
    tick();
    reset = 1'b0; valid = 1'b0; resp = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    resp = 1'b0; #1;
    check("stale_wbv", 64'(wbv), 64'h0);
    check("stale_mrv", 64'(mrv), 64'h0);
    check("stale_wb", 64'(wb), 64'h0);
    valid = 1'b1; #1;
    check("stale_idle_hold", 64'(hold), 64'h1);
    valid = 1'b0;

    // Misaligned LW at 0x2
    tick();
    valid = 1'b1; mem_rr = 1'b1; f3 = 3'b010; alu = 32'h0000_0002; #1;
`ifdef WB_MISALIGN_TRAP_EN
    check("mis_flag", 64'(mis), 64'h1);
    check("mis_hold", 64'(hold), 64'h0);
    check("mis_wbv", 64'(wbv), 64'h1);
    check("mis_wb", 64'(wb), 64'h0);
    tick();
    check("mis_mrv", 64'(mrv), 64'h0);
    valid = 1'b0;
`else
    check("mis_flag", 64'(mis), 64'h0);
    check("mis_hold", 64'(hold), 64'h1);
    tick();
    ready = 1'b1; resp = 1'b1; rdata = 32'hAABB_CCDD; #1;
    check("mis_mrv", 64'(mrv), 64'h1);
    tick();
    ready = 1'b0; resp = 1'b0; #1;
    check("mis_wb", 64'(wb), 64'h0000_AABB);
    check("mis_wbv", 64'(wbv), 64'h1);
    tick();
    valid = 1'b0;
`endif
    mem_rr = 1'b0;

    // XLEN=64 SD @0x8, ready immediately
    valid64 = 1'b1; mem_we64 = 1'b1; f364 = 3'b011; alu64 = 64'h8;
    sdata64 = 64'h1122_3344_5566_7788; ready64 = 1'b1; #1;
    check("sd_idle_hold", hold64, 64'h1);
    check("sd_idle_mrv", 64'(mrv64), 64'h0);
    tick();
    check("sd_req_mrv", 64'(mrv64), 64'h1);
    check("sd_req_wr", 64'(mwr64), 64'h1);
    check("sd_wmask", 64'(mwmask64), 64'hFF);
    check("sd_wdata", mwdata64, 64'h1122_3344_5566_7788);
    tick();
    ready64 = 1'b0; #1;
    check("sd_done_mrv", 64'(mrv64), 64'h0);
    check("sd_done_wbv", 64'(wbv64), 64'h1);
    check("sd_done_hold", 64'(hold64), 64'h0);
    tick();
    mem_we64 = 1'b0;

    // XLEN=64 LD with same-cycle response, then LW/LWU of the upper word
    mem_rr64 = 1'b1; reg_we64 = 1'b1; f364 = 3'b011; alu64 = 64'h10;
    tick();
    ready64 = 1'b1; resp64 = 1'b1; rdata64 = 64'h8877_6655_4433_2211;
    tick();
    ready64 = 1'b0; resp64 = 1'b0; #1;
    check("ld_wb", wb64, 64'h8877_6655_4433_2211);
    f364 = 3'b010; alu64 = 64'h14; #1;
    check("lw64_wb", wb64, 64'hFFFF_FFFF_8877_6655);
    f364 = 3'b110; #1;
    check("lwu64_wb", wb64, 64'h0000_0000_8877_6655);
    tick();
    valid64 = 1'b0; mem_rr64 = 1'b0; #1;
    check("ld_idle_mrv", 64'(mrv64), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
